// File: rtl/dff_var.sv
// Bank of DEPTH independent WIDTH-bit registers sharing one write-data bus.
// Each entry is a hold/load mux feeding a flip-flop stage, all contents exposed in parallel.

module mux2_1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = i0;
    if (sel) y = i1;
  end
endmodule

module dff_cell #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= d;
  end

  assign q = data_q;
endmodule

module dff_var #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DEPTH-1:0]            wr,
  input  logic [WIDTH-1:0]            in,
  output logic [DEPTH-1:0][WIDTH-1:0] out
);
  logic [DEPTH-1:0][WIDTH-1:0] entry_d;
  logic [DEPTH-1:0][WIDTH-1:0] entry_q;

  // Every entry recirculates its own value unless its write enable selects the shared bus.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    mux2_1 #(.WIDTH(WIDTH)) u_load_mux (
      .i0  (entry_q[gi]),
      .i1  (in),
      .sel (wr[gi]),
      .y   (entry_d[gi])
    );

    dff_cell #(.WIDTH(WIDTH)) u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (entry_d[gi]),
      .q     (entry_q[gi])
    );
  end

  assign out = entry_q;
endmodule

// File: tb/tb_dff_var.sv
// Directed, table-driven check of the dff_var register bank,
// plus hand-written reset sequences.

module tb_dff_var;
  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam logic [63:0] BCAST = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] TOPV  = 64'h8000_0000_0000_0001;

  logic                        clk;
  logic                        rst_n;
  logic [DEPTH-1:0]            wr;
  logic [WIDTH-1:0]            din;
  logic [DEPTH-1:0][WIDTH-1:0] dout;

  int n_total;
  int n_pass;

  dff_var #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .in    (din),
    .out   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sweep: 0 none, 1 after one-hot/hold, 2 after broadcast, 3 after entry-31 write
  typedef struct {
    logic [31:0] wr;
    logic [63:0] din;
    int          ia;
    logic [63:0] ea;
    int          ib;
    logic [63:0] eb;
    int          sweep;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [31:0] w, logic [63:0] d, int ia, logic [63:0] ea,
                              int ib, logic [63:0] eb, int sw);
    vec_t v;
    v.wr = w; v.din = d; v.ia = ia; v.ea = ea; v.ib = ib; v.eb = eb; v.sweep = sw;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s out[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic check_all_zero(string name);
    for (int i = 0; i < DEPTH; i++) check(name, i, dout[i], 64'h0);
  endtask

  function automatic logic [63:0] sweep_exp(int sw, int i);
    case (sw)
      1:       return (i < 8) ? 64'(i + 1) : 64'h0;
      2:       return BCAST;
      default: return (i == 31) ? TOPV : BCAST;
    endcase
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = mk(32'h01, 64'd1, 0, 64'd1, 1, 64'd0, 0);
    vecs[1]  = mk(32'h02, 64'd2, 1, 64'd2, 0, 64'd1, 0);
    vecs[2]  = mk(32'h04, 64'd3, 2, 64'd3, 3, 64'd0, 0);
    vecs[3]  = mk(32'h08, 64'd4, 3, 64'd4, 2, 64'd3, 0);
    vecs[4]  = mk(32'h10, 64'd5, 4, 64'd5, 5, 64'd0, 0);
    vecs[5]  = mk(32'h20, 64'd6, 5, 64'd6, 4, 64'd5, 0);
    vecs[6]  = mk(32'h40, 64'd7, 6, 64'd7, 7, 64'd0, 0);
    vecs[7]  = mk(32'h80, 64'd8, 7, 64'd8, 8, 64'd0, 1);
    vecs[8]  = mk(32'h0, '1, 0, 64'd1, 7, 64'd8, 0);
    vecs[9]  = mk(32'h0, '1, 1, 64'd2, 6, 64'd7, 0);
    vecs[10] = mk(32'h0, '1, 2, 64'd3, 8, 64'd0, 0);
    vecs[11] = mk(32'h0, '1, 3, 64'd4, 31, 64'd0, 0);
    vecs[12] = mk(32'h0, '1, 4, 64'd5, 5, 64'd6, 1);
    vecs[13] = mk(32'hFFFF_FFFF, BCAST, 0, BCAST, 31, BCAST, 2);
    vecs[14] = mk(32'h8000_0000, TOPV, 31, TOPV, 30, BCAST, 3);
    vecs[15] = mk(32'h0, 64'h1234, 31, TOPV, 0, BCAST, 3);

    // Power-on reset with garbage on the inputs.
    rst_n = 1'b0;
    wr    = '1;
    din   = '1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    $display("txn reset_init: rst_n low, wr=%h", wr);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      wr  = vecs[v].wr;
      din = vecs[v].din;
      @(posedge clk);
      #1;
      $display("txn %0d: wr=%h in=%h out[%0d]=%h out[%0d]=%h", v, vecs[v].wr, vecs[v].din,
               vecs[v].ia, dout[vecs[v].ia], vecs[v].ib, dout[vecs[v].ib]);
      check("vec_a", vecs[v].ia, dout[vecs[v].ia], vecs[v].ea);
      check("vec_b", vecs[v].ib, dout[vecs[v].ib], vecs[v].eb);
      if (vecs[v].sweep != 0)
        for (int i = 0; i < DEPTH; i++) check("sweep", i, dout[i], sweep_exp(vecs[v].sweep, i));
    end

    // Asynchronous reset pulse between edges clears everything immediately.
    wr = '0;
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async_reset: rst_n dropped between edges");
    check_all_zero("async_reset");

    // Writes are ignored while reset is held.
    wr  = 32'h1;
    din = 64'h55;
    @(posedge clk);
    #1;
    $display("txn reset_hold: wr=%h in=%h out[0]=%h", wr, din, dout[0]);
    check("reset_hold", 0, dout[0], 64'h0);

    // First edge after release loads.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("txn first_load: out[0]=%h", dout[0]);
    check("first_load", 0, dout[0], 64'h55);
    check("first_load_iso", 1, dout[1], 64'h0);

    // Reset dropped just before an edge discards the write in flight.
    wr  = 32'h2;
    din = 64'h77;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("txn mid_write_reset: out[0]=%h out[1]=%h", dout[0], dout[1]);
    check("mid_write_e0", 0, dout[0], 64'h0);
    check("mid_write_e1", 1, dout[1], 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    wr    = 32'h1;
    din   = 64'h55;
    @(posedge clk);
    #1;
    $display("txn post_release_load: out[0]=%h out[1]=%h", dout[0], dout[1]);
    check("post_release_e0", 0, dout[0], 64'h55);
    check("post_release_e1", 1, dout[1], 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
